johnson_phase_decoder: RTL and testbench
========================================

# johnson_phase_decoder

Downstream consumer of the 4-bit Johnson counter. It samples the counter's `cnt` bus and decodes each code into a phase index and a one-hot phase vector. It checks that every code is legal and in sequence, acquires and holds a lock, and counts full revolutions. It sits in the same clock domain as the counter and gives later logic clean per-phase enables plus a health indication.

## Interface
Parameters:
- `REV_W`, default 16: width of the revolution counter.
- `LOCK_CNT`, default 8: consecutive legal advances needed to assert `locked`. Must be ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cnt`  in  4  Johnson code from the upstream counter, synchronous to `clk`.
- `err_clr`  in  1  clears the sticky error flags.
- `phase`  out  3  decoded phase index 0..7.
- `phase_onehot`  out  8  bit[`phase`] set when the code is valid, otherwise all zero.
- `phase_valid`  out  1  the current sampled code is legal.
- `rev_pulse`  out  1  one-cycle pulse on each phase 7→0 advance.
- `rev_cnt`  out  `REV_W`  count of revolutions, wraps.
- `illegal_err`  out  1  sticky: an illegal code was seen.
- `seq_err`  out  1  sticky: an out-of-sequence transition was seen.
- `locked`  out  1  decoder is locked to a legal running sequence.

## Operation
- **Legal codes.** The upstream counter shifts left with the inverted MSB fed into the LSB. The legal codes and their phases are:
  - 0000=p0, 0001=p1, 0011=p2, 0111=p3
  - 1111=p4, 1110=p5, 1100=p6, 1000=p7
  - All other 8 codes are illegal.
- **Input stage.** `cnt` is registered into `cnt_q` every cycle. A previous-sample register holds the prior decoded phase plus a prev_ok bit.
- **Transition classes.** Each legal sample is classified against the previous one, only when prev_ok=1:
  - Hold: same phase.
  - Advance: phase = prev+1 mod 8.
  - Skip: anything else.
- **No previous sample.** The first legal sample after reset, or after an illegal code, is a start. It is not checked for sequence.
- **Illegal code:**
  - Sets `illegal_err`.
  - `phase_valid`=0 and `phase_onehot`=0; `phase` holds its last value.
  - Clears prev_ok.
- **Skip:** sets `seq_err`. The new phase becomes the previous phase (prev_ok=1).
- **Revolutions.** An advance from 7 to 0 pulses `rev_pulse` and increments `rev_cnt` mod 2^`REV_W`. This happens regardless of lock state.
- **Lock FSM (states UNLOCK, ACQ, LOCK):**
  - UNLOCK → ACQ on any legal sample; the acquisition counter is set to 0.
  - In ACQ, an advance increments the acquisition counter and a hold leaves it unchanged. When the counter reaches `LOCK_CNT`, go to LOCK.
  - In LOCK, holds and advances stay in LOCK.
  - Illegal or skip in ACQ or LOCK → UNLOCK.
  - `locked`=1 only in LOCK.
- **Sticky flags.**
  - `err_clr` clears `illegal_err` and `seq_err`.
  - A new error in the same cycle as `err_clr` wins; the flag stays 1.
  - `err_clr` does not affect the lock FSM or `rev_cnt`.

## Timing
- **Reset.** While `reset` is asserted, all outputs are 0 immediately (asynchronously): `phase`=0, `phase_onehot`=0, `phase_valid`=0, `rev_pulse`=0, `rev_cnt`=0, both error flags 0, `locked`=0. The FSM is in UNLOCK and prev_ok=0.
- **Latency.** Two cycles:
  - A code present on `cnt` at edge N is in `cnt_q` after edge N.
  - Its decode, error flags, `rev_pulse` and FSM state are registered at edge N+1.
- **`locked` rise.** `locked` rises at the edge that registers the `LOCK_CNT`-th advance.
- **`locked` fall.** `locked` falls at the same edge that sets `illegal_err` or `seq_err`.
- **`rev_pulse`.** High for exactly one cycle per 7→0 advance. `rev_cnt` updates at the same edge.
- **Reset mid-operation.** All state is discarded. After release, the first legal code is a start: no `seq_err`, and acquisition restarts from 0.
- **Upstream reset.** An upstream counter held in reset presents 0000 repeatedly. The decoder treats this as holds at p0: no error.

## Test plan
1. **Lock and revolution.** Release reset with the counter free-running (`LOCK_CNT`=8) → `phase` steps 0..7 two cycles behind `cnt`; `locked`=1 after the 8th advance; `rev_pulse` fires once per 8 cycles; `rev_cnt` reaches 3 after 3 revolutions.
2. **Illegal code.** While locked, force `cnt`=0101 for one cycle → `illegal_err`=1, `phase_valid`=0, `phase_onehot`=0, `locked`=0, `seq_err`=0. Normal codes resume → `locked`=1 again after 8 advances.
3. **Skip.** Drive 0011 then 1111 (p2→p4) → `seq_err`=1, `illegal_err`=0, `locked`=0, `phase`=4. A later 1111→1110 is a normal advance.
4. **Hold.** Hold `cnt`=0111 for 5 cycles while locked → no error flags, `locked` stays 1, no `rev_pulse`. In ACQ, the same hold does not advance acquisition.
5. **Wrap.** With `REV_W`=2, run 5 revolutions → `rev_cnt` sequence 1,2,3,0,1.
6. **Clear and reset.**
   - `err_clr` alone → both flags return to 0 the next cycle.
   - `err_clr` in the same cycle as a new illegal code → `illegal_err` stays 1.
   - Assert `reset` mid-revolution → all outputs are 0 without waiting for a clock edge.

Source files
------------

// File: rtl/johnson_phase_decoder.sv
// Decodes a 4-bit Johnson counter bus into a phase index and a one-hot enable.
// It also tracks sequence health, lock state and completed revolutions.
module johnson_phase_decoder #(
    parameter int REV_W    = 16,
    parameter int LOCK_CNT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cnt,
    input  logic             err_clr,
    output logic [2:0]       phase,
    output logic [7:0]       phase_onehot,
    output logic             phase_valid,
    output logic             rev_pulse,
    output logic [REV_W-1:0] rev_cnt,
    output logic             illegal_err,
    output logic             seq_err,
    output logic             locked
);

    localparam int ACQ_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        S_UNLOCK = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCK   = 2'd2
    } lock_state_t;

    logic [3:0]       r_cnt_q;
    logic             r_cnt_vld;
    logic [2:0]       r_phase;
    logic             r_prev_ok;
    logic [7:0]       r_onehot;
    logic             r_phase_valid;
    logic             r_rev_pulse;
    logic [REV_W-1:0] r_rev_cnt;
    logic             r_illegal_err;
    logic             r_seq_err;
    lock_state_t      r_state;
    lock_state_t      w_state_nxt;
    logic [ACQ_W-1:0] r_acq;
    logic [ACQ_W-1:0] w_acq_nxt;

    logic             w_legal;
    logic [2:0]       w_phase;
    logic [2:0]       w_phase_inc;
    logic             w_good;
    logic             w_bad;
    logic             w_hold;
    logic             w_adv;
    logic             w_skip;
    logic             w_wrap;

    // Stage 1: capture the raw code. r_cnt_vld keeps the reset value of
    // r_cnt_q (0000, a legal code) from being decoded as a real sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_q   <= 4'b0000;
            r_cnt_vld <= 1'b0;
        end else begin
            r_cnt_q   <= cnt;
            r_cnt_vld <= 1'b1;
        end
    end

    always_comb begin
        w_legal = 1'b1;
        w_phase = 3'd0;
        case (r_cnt_q)
            4'b0000: w_phase = 3'd0;
            4'b0001: w_phase = 3'd1;
            4'b0011: w_phase = 3'd2;
            4'b0111: w_phase = 3'd3;
            4'b1111: w_phase = 3'd4;
            4'b1110: w_phase = 3'd5;
            4'b1100: w_phase = 3'd6;
            4'b1000: w_phase = 3'd7;
            default: w_legal = 1'b0;
        endcase
    end

    // r_phase doubles as the previous-sample phase; it only moves on legal codes.
    assign w_phase_inc = r_phase + 3'd1;
    assign w_good      = r_cnt_vld & w_legal;
    assign w_bad       = r_cnt_vld & ~w_legal;
    assign w_hold      = w_good & r_prev_ok & (w_phase == r_phase);
    assign w_adv       = w_good & r_prev_ok & (w_phase == w_phase_inc);
    assign w_skip      = w_good & r_prev_ok & ~w_hold & ~w_adv;
    assign w_wrap      = w_adv & (r_phase == 3'd7);

    // Stage 2: registered decode, revolution count and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase       <= 3'd0;
            r_prev_ok     <= 1'b0;
            r_onehot      <= 8'd0;
            r_phase_valid <= 1'b0;
            r_rev_pulse   <= 1'b0;
            r_rev_cnt     <= '0;
            r_illegal_err <= 1'b0;
            r_seq_err     <= 1'b0;
        end else begin
            if (w_good) begin
                r_phase       <= w_phase;
                r_prev_ok     <= 1'b1;
                r_onehot      <= 8'd1 << w_phase;
                r_phase_valid <= 1'b1;
            end else if (w_bad) begin
                r_prev_ok     <= 1'b0;
                r_onehot      <= 8'd0;
                r_phase_valid <= 1'b0;
            end
            r_rev_pulse <= w_wrap;
            if (w_wrap) begin
                r_rev_cnt <= r_rev_cnt + REV_W'(1);
            end
            // A fresh error outranks a simultaneous clear.
            r_illegal_err <= w_bad  | (r_illegal_err & ~err_clr);
            r_seq_err     <= w_skip | (r_seq_err & ~err_clr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_UNLOCK;
            r_acq   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acq   <= w_acq_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acq_nxt   = r_acq;
        case (r_state)
            S_UNLOCK: begin
                if (w_good) begin
                    w_state_nxt = S_ACQ;
                    w_acq_nxt   = '0;
                end
            end
            S_ACQ: begin
                if (w_bad || w_skip) begin
                    w_state_nxt = S_UNLOCK;
                end else if (w_adv) begin
                    w_acq_nxt = r_acq + ACQ_W'(1);
                    if (r_acq == ACQ_W'(LOCK_CNT - 1)) begin
                        w_state_nxt = S_LOCK;
                    end
                end
            end
            S_LOCK: begin
                if (w_bad || w_skip) begin
                    w_state_nxt = S_UNLOCK;
                end
            end
            default: w_state_nxt = S_UNLOCK;
        endcase
    end

    always_comb begin
        locked = (r_state == S_LOCK);
    end

    assign phase        = r_phase;
    assign phase_onehot = r_onehot;
    assign phase_valid  = r_phase_valid;
    assign rev_pulse    = r_rev_pulse;
    assign rev_cnt      = r_rev_cnt;
    assign illegal_err  = r_illegal_err;
    assign seq_err      = r_seq_err;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed plus randomized bench for johnson_phase_decoder, checked against
// a phase-table reference model of the decoder's rules.
module tb_johnson_phase_decoder;

    localparam int REV_W_TB = 2;
    localparam int LOCK_TB  = 8;

    logic                clk;
    logic                reset;
    logic [3:0]          cnt;
    logic                err_clr;
    logic [2:0]          phase;
    logic [7:0]          phase_onehot;
    logic                phase_valid;
    logic                rev_pulse;
    logic [REV_W_TB-1:0] rev_cnt;
    logic                illegal_err;
    logic                seq_err;
    logic                locked;

    johnson_phase_decoder #(.REV_W(REV_W_TB), .LOCK_CNT(LOCK_TB)) dut (
        .clk(clk), .reset(reset), .cnt(cnt), .err_clr(err_clr),
        .phase(phase), .phase_onehot(phase_onehot), .phase_valid(phase_valid),
        .rev_pulse(rev_pulse), .rev_cnt(rev_cnt), .illegal_err(illegal_err),
        .seq_err(seq_err), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int jc_tab[8]  = '{0, 1, 3, 7, 15, 14, 12, 8};
    int bad_tab[8] = '{2, 4, 5, 6, 9, 10, 11, 13};

    // Reference model state: a one-sample input pipe plus the expected outputs.
    int m_q;
    bit m_q_vld;
    bit m_prev_ok;
    int m_phase;
    int m_onehot;
    bit m_valid;
    bit m_pulse;
    int m_rev;
    bit m_ill;
    bit m_seq;
    bit m_locked;
    bit m_acqing;
    int m_acq;
    int g_ph;

    function automatic int phase_of(input int code);
        for (int i = 0; i < 8; i++) begin
            if (jc_tab[i] == code) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_q_vld = 0; m_prev_ok = 0; m_phase = 0; m_onehot = 0;
        m_valid = 0; m_pulse = 0; m_rev = 0; m_ill = 0; m_seq = 0;
        m_locked = 0; m_acqing = 0; m_acq = 0;
    endtask

    task automatic model_step(input int code, input bit clr);
        bit new_ill;
        bit new_seq;
        int p;
        int kind;   // 0 start, 1 hold, 2 advance, 3 skip
        new_ill = 0;
        new_seq = 0;
        m_pulse = 0;
        if (m_q_vld) begin
            p = phase_of(m_q);
            if (p < 0) begin
                new_ill = 1;
                m_valid = 0;
                m_onehot = 0;
                m_prev_ok = 0;
                m_locked = 0;
                m_acqing = 0;
            end else begin
                if (!m_prev_ok) kind = 0;
                else if (p == m_phase) kind = 1;
                else if (p == (m_phase + 1) % 8) kind = 2;
                else kind = 3;
                if (kind == 2 && m_phase == 7) begin
                    m_pulse = 1;
                    m_rev = (m_rev + 1) % (1 << REV_W_TB);
                end
                if (kind == 3) new_seq = 1;
                if (!m_locked && !m_acqing) begin
                    m_acqing = 1;
                    m_acq = 0;
                end else if (kind == 3) begin
                    m_locked = 0;
                    m_acqing = 0;
                end else if (m_acqing && kind == 2) begin
                    m_acq++;
                    if (m_acq == LOCK_TB) begin
                        m_acqing = 0;
                        m_locked = 1;
                    end
                end
                m_phase = p;
                m_valid = 1;
                m_onehot = 1 << p;
                m_prev_ok = 1;
            end
        end
        m_ill = new_ill || (m_ill && !clr);
        m_seq = new_seq || (m_seq && !clr);
        m_q = code;
        m_q_vld = 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_phase"},  32'(phase),        32'(m_phase));
        chk({tag, "_onehot"}, 32'(phase_onehot), 32'(m_onehot));
        chk({tag, "_valid"},  32'(phase_valid),  32'(m_valid));
        chk({tag, "_pulse"},  32'(rev_pulse),    32'(m_pulse));
        chk({tag, "_revcnt"}, 32'(rev_cnt),      32'(m_rev));
        chk({tag, "_ill"},    32'(illegal_err),  32'(m_ill));
        chk({tag, "_seq"},    32'(seq_err),      32'(m_seq));
        chk({tag, "_locked"}, 32'(locked),       32'(m_locked));
    endtask

    task automatic tick(input int code, input bit clr, input string tag);
        cnt = 4'(code);
        err_clr = clr;
        @(posedge clk);
        model_step(code, clr);
        #1;
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick(jc_tab[g_ph], 1'b0, tag);
            g_ph = (g_ph + 1) % 8;
        end
    endtask

    // Asserts reset partway through the high clock phase; outputs must clear
    // before any further clock edge.
    task automatic async_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        chk({tag, "_rphase"},  32'(phase),        0);
        chk({tag, "_ronehot"}, 32'(phase_onehot), 0);
        chk({tag, "_rvalid"},  32'(phase_valid),  0);
        chk({tag, "_rpulse"},  32'(rev_pulse),    0);
        chk({tag, "_rrevcnt"}, 32'(rev_cnt),      0);
        chk({tag, "_rill"},    32'(illegal_err),  0);
        chk({tag, "_rseq"},    32'(seq_err),      0);
        chk({tag, "_rlocked"}, 32'(locked),       0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        g_ph = 0;
    endtask

    initial begin
        int r;
        reset = 1'b1;
        cnt = 4'd0;
        err_clr = 1'b0;
        g_ph = 0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Lock and three revolutions from a free-running counter.
        run(30, "run");
        chk("run_locked_const", 32'(locked), 1);

        // Single illegal code while locked, then reacquire.
        tick(5, 1'b0, "illegal");
        tick(jc_tab[g_ph], 1'b0, "ill_next");
        chk("ill_flag_const", 32'(illegal_err), 1);
        chk("ill_valid_const", 32'(phase_valid), 0);
        run(14, "reacq");

        // Skip p2 -> p4, then a normal p4 -> p5 advance.
        tick(3, 1'b0, "skip_a");
        tick(15, 1'b0, "skip_b");
        tick(14, 1'b0, "skip_c");
        chk("skip_seq_const", 32'(seq_err), 1);
        chk("skip_phase_const", 32'(phase), 4);
        g_ph = 6;
        run(14, "post_skip");

        // Hold at p3 while locked, and again while acquiring.
        g_ph = 0;
        run(12, "pre_hold");
        for (int i = 0; i < 5; i++) tick(7, 1'b0, "hold_lock");
        g_ph = 4;
        run(4, "post_hold");
        tick(9, 1'b0, "to_unlock");
        g_ph = 0;
        run(4, "acq_start");
        for (int i = 0; i < 5; i++) tick(7, 1'b0, "hold_acq");
        g_ph = 4;
        run(12, "acq_finish");

        // Clear alone, then clear colliding with a new illegal code.
        tick(jc_tab[g_ph], 1'b1, "clr_alone");
        g_ph = (g_ph + 1) % 8;
        tick(jc_tab[g_ph], 1'b0, "clr_settle");
        tick(jc_tab[g_ph], 1'b0, "clr_check");
        tick(11, 1'b0, "clr_bad");
        tick(jc_tab[g_ph], 1'b1, "clr_collide");
        chk("clr_collide_const", 32'(illegal_err), 1);

        // Upstream held in reset: repeated 0000 after a reset is just holds.
        async_reset("rst_mid");
        for (int i = 0; i < 6; i++) tick(0, 1'b0, "upstream_rst");
        g_ph = 1;
        run(44, "wrap");

        // Randomized mix of advances, holds, skips, illegal codes and clears.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset("rst_rand");
            r = $urandom_range(0, 99);
            if (r < 72) begin
                tick(jc_tab[g_ph], ($urandom_range(0, 15) == 0), "rnd_adv");
                g_ph = (g_ph + 1) % 8;
            end else if (r < 84) begin
                tick(jc_tab[(g_ph + 7) % 8], ($urandom_range(0, 15) == 0), "rnd_hold");
            end else if (r < 92) begin
                g_ph = $urandom_range(0, 7);
                tick(jc_tab[g_ph], ($urandom_range(0, 15) == 0), "rnd_skip");
                g_ph = (g_ph + 1) % 8;
            end else begin
                tick(bad_tab[$urandom_range(0, 7)], ($urandom_range(0, 3) == 0), "rnd_bad");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
